fir_driver: RTL



---
 rtl/fir_pkg.sv | 13 +
 rtl/fir_edge_detect.sv | 13 +
 rtl/fir_driver.sv | 118 +++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, timeouts, Q1.15 constants and FSM states for the FIR driver.
package fir_pkg;
  localparam int DW        = 16;
  localparam int NCOEFF    = 4;
  localparam int C_TIMEOUT = 10;
  localparam int S_TIMEOUT = 25;
  localparam logic [DW-1:0] Q_ONE     = 16'h8000;
  localparam logic [DW-1:0] Q_HALF    = 16'h4000;
  localparam logic [DW-1:0] Q_QUARTER = 16'h2000;
  localparam logic [DW-1:0] Q_EIGHTH  = 16'h1000;
  localparam logic [DW-1:0] Q_ZERO    = 16'h0000;
  typedef enum logic [2:0] {IDLE, C_SEND, C_WAIT, S_SEND, S_WAIT, CAPTURE} state_t;
endpackage

// File: rtl/fir_edge_detect.sv
// fir_edge_detect: registers the filter busy flag and strobes its rising and falling edges.
module fir_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);
  logic r_q;
  always_ff @(posedge clk) r_q <= reset ? 1'b0 : i_sig;
  assign o_rise = i_sig & ~r_q;
  assign o_fall = r_q & ~i_sig;
endmodule

// File: rtl/fir_driver.sv
// fir_driver: buffers 4 coefficients, feeds them and samples to a FIR filter over a modwait handshake.
module fir_driver
  import fir_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] coeff_in,
  input  logic          coeff_wr,
  input  logic          start_coeff,
  input  logic [DW-1:0] sample_in,
  input  logic          sample_valid,
  output logic          sample_ready,
  output logic [DW-1:0] fir_sample,
  output logic [DW-1:0] fir_coeff,
  output logic          data_ready,
  output logic          load_coeff,
  input  logic          modwait,
  input  logic [DW-1:0] fir_out,
  input  logic          fir_err,
  output logic [DW-1:0] result,
  output logic          result_err,
  output logic          result_valid,
  output logic          busy,
  output logic          timeout
);
  localparam int IW = $clog2(NCOEFF);
  localparam int WW = $clog2(S_TIMEOUT + 1);
  state_t        r_state, w_next;
  logic [DW-1:0] r_buf [NCOEFF];
  logic [IW-1:0] r_wptr, r_idx;
  logic [WW-1:0] r_wdog;
  logic [DW-1:0] r_sample, r_coeff, r_result;
  logic          r_result_err, r_timeout;
  logic          w_rise, w_fall, w_accept, w_start, w_expire, w_clr;

  fir_edge_detect u_edge (
    .clk    (clk),
    .reset  (reset),
    .i_sig  (modwait),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_start  = (r_state == IDLE) && start_coeff;
  assign w_accept = (r_state == IDLE) && !start_coeff && sample_valid;

  always_comb begin
    w_next   = r_state;
    w_expire = 1'b0;
    case (r_state)
      IDLE:    w_next = start_coeff ? C_SEND : sample_valid ? S_SEND : IDLE;
      C_SEND:  w_next = (r_wdog == WW'(1)) ? C_WAIT : C_SEND;
      C_WAIT: begin
        w_expire = !w_fall && (r_wdog >= WW'(C_TIMEOUT - 1));
        w_next   = w_fall ? ((r_idx == IW'(NCOEFF - 1)) ? IDLE : C_SEND) : w_expire ? IDLE : C_WAIT;
      end
      S_SEND: begin
        w_expire = !w_rise && (r_wdog >= WW'(S_TIMEOUT - 1));
        w_next   = w_rise ? S_WAIT : w_expire ? IDLE : S_SEND;
      end
      S_WAIT: begin
        w_expire = !w_fall && (r_wdog >= WW'(S_TIMEOUT - 1));
        w_next   = w_fall ? CAPTURE : w_expire ? IDLE : S_WAIT;
      end
      default: w_next = IDLE;
    endcase
  end

  // the sample watchdog spans S_SEND and S_WAIT, so that hand-over does not clear it
  assign w_clr = (w_next != r_state) && !(r_state == S_SEND && w_next == S_WAIT);

  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr       <= '0;
      r_idx        <= '0;
      r_wdog       <= '0;
      r_sample     <= '0;
      r_coeff      <= '0;
      r_result     <= '0;
      r_result_err <= 1'b0;
      r_timeout    <= 1'b0;
      for (int i = 0; i < NCOEFF; i++) r_buf[i] <= '0;
    end else begin
      if (r_state == IDLE && coeff_wr) begin
        r_buf[r_wptr] <= coeff_in;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_accept) r_sample <= sample_in;
      if (w_start) begin
        r_idx   <= '0;
        r_coeff <= r_buf[0];
      end
      if (r_state == C_WAIT && w_fall) begin
        r_idx   <= r_idx + 1'b1;
        r_coeff <= r_buf[r_idx + 1'b1];
      end
      if (r_state == S_WAIT && w_fall) begin
        r_result     <= fir_out;
        r_result_err <= fir_err;
      end
      if (w_expire) r_timeout <= 1'b1;
      r_wdog <= (w_clr || r_state == IDLE) ? '0 : r_wdog + 1'b1;
    end
  end

  assign sample_ready = w_accept;
  assign fir_sample   = r_sample;
  assign fir_coeff    = r_coeff;
  assign data_ready   = (r_state == S_SEND);
  assign load_coeff   = (r_state == C_SEND);
  assign result       = r_result;
  assign result_err   = r_result_err;
  assign result_valid = (r_state == CAPTURE);
  assign busy         = (r_state != IDLE);
  assign timeout      = r_timeout;
endmodule
